video_rect_fill: RTL



---
 rtl/video_pkg.sv | 38 +++
 rtl/video_rect_fill_if.sv | 41 ++++
 rtl/video_rect_clip.sv | 28 ++
 rtl/video_rect_fill.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and default screen geometry for the rectangle fill engine and
// its environment.
package video_pkg;

    localparam int DEF_H_SIZE = 320;
    localparam int DEF_V_SIZE = 240;

    localparam int CMD_XW = 10;
    localparam int CMD_YW = 10;
    localparam int CMD_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } rect_state_t;

    // Rectangle command as seen on the command port, inclusive corners.
    typedef struct packed {
        logic [CMD_XW-1:0] x0;
        logic [CMD_YW-1:0] y0;
        logic [CMD_XW-1:0] x1;
        logic [CMD_YW-1:0] y1;
        logic [CMD_DW-1:0] color;
    } rect_cmd_t;

    function automatic int unsigned rect_pixels(input rect_cmd_t c, input int h_size,
                                                input int v_size);
        int unsigned xe;
        int unsigned ye;
        xe = (int'(c.x1) > h_size - 1) ? h_size - 1 : c.x1;
        ye = (int'(c.y1) > v_size - 1) ? v_size - 1 : c.y1;
        if (c.x0 > xe || c.y0 > ye) return 0;
        return (xe - c.x0 + 1) * (ye - c.y0 + 1);
    endfunction

endpackage

// File: rtl/video_rect_fill_if.sv
// Command port plus Avalon-MM write initiator port of the rectangle fill engine.
interface video_rect_fill_if #(
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int AVN_AW = 18,
    parameter int AVN_DW = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [XW-1:0]     cmd_x0;
    logic [YW-1:0]     cmd_y0;
    logic [XW-1:0]     cmd_x1;
    logic [YW-1:0]     cmd_y1;
    logic [AVN_DW-1:0] cmd_color;
    logic              busy;
    logic              done;

    logic                framebuffer_avn_write;
    logic [AVN_AW-1:0]   framebuffer_avn_address;
    logic [AVN_DW-1:0]   framebuffer_avn_writedata;
    logic [AVN_DW/8-1:0] framebuffer_avn_byteenable;
    logic                framebuffer_avn_waitrequest;

    // master: the fill engine; slave: command source plus framebuffer responder
    modport master (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready, busy, done,
        output framebuffer_avn_write, framebuffer_avn_address,
        output framebuffer_avn_writedata, framebuffer_avn_byteenable,
        input  framebuffer_avn_waitrequest
    );

    modport slave (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready, busy, done,
        input  framebuffer_avn_write, framebuffer_avn_address,
        input  framebuffer_avn_writedata, framebuffer_avn_byteenable,
        output framebuffer_avn_waitrequest
    );

endinterface

// File: rtl/video_rect_clip.sv
// Clips a latched rectangle against the visible screen and flags rectangles
// that cover no visible pixel.
module video_rect_clip #(
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int H_SIZE = 320,
    parameter int V_SIZE = 240
) (
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] xe,
    output logic [YW-1:0] ye,
    output logic          empty
);
    import video_pkg::*;

    localparam logic [XW-1:0] X_MAX = XW'(H_SIZE - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_SIZE - 1);

    assign xe = (x1 > X_MAX) ? X_MAX : x1;
    assign ye = (y1 > Y_MAX) ? Y_MAX : y1;

    // Inverted corners are treated as empty rather than swapped.
    assign empty = (x0 > xe) || (y0 > ye);

endmodule

// File: rtl/video_rect_fill.sv
// Rectangle fill engine: clips one command to the screen and paints it with one
// Avalon-MM single-word write per pixel in raster order.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | clipped bounds settle, row base multiply registered
// WRITE | one write per pixel, advancing on each accepted write
// DONE  | one-cycle completion pulse, then back to IDLE
module video_rect_fill #(
    parameter int AVN_AW = 18,
    parameter int AVN_DW = 16,
    parameter int H_SIZE = video_pkg::DEF_H_SIZE,
    parameter int V_SIZE = video_pkg::DEF_V_SIZE,
    parameter int XW     = 10,
    parameter int YW     = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    video_rect_fill_if.master bus
);
    import video_pkg::*;

    localparam logic [AVN_AW-1:0] STRIDE = AVN_AW'(H_SIZE);

    rect_state_t state_q;
    rect_state_t state_d;

    logic [XW-1:0]     x0_q;
    logic [XW-1:0]     x1_q;
    logic [YW-1:0]     y0_q;
    logic [YW-1:0]     y1_q;
    logic [AVN_DW-1:0] color_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [AVN_AW-1:0] row_base_q;

    logic [XW-1:0] xe;
    logic [YW-1:0] ye;
    logic          empty;

    logic ready;
    logic busy;
    logic done;
    logic write;
    logic accept;
    logic step;
    logic last_px;

    video_rect_clip #(
        .XW     (XW),
        .YW     (YW),
        .H_SIZE (H_SIZE),
        .V_SIZE (V_SIZE)
    ) u_clip (
        .x0    (x0_q),
        .y0    (y0_q),
        .x1    (x1_q),
        .y1    (y1_q),
        .xe    (xe),
        .ye    (ye),
        .empty (empty)
    );

    assign accept  = ready && bus.cmd_valid;
    assign step    = write && !bus.framebuffer_avn_waitrequest;
    assign last_px = (x_q == xe) && (y_q == ye);

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        write   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (bus.cmd_valid) state_d = SETUP;
            end
            SETUP: begin
                state_d = empty ? DONE : WRITE;
            end
            WRITE: begin
                write = 1'b1;
                if (step && last_px) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
        end else begin
            if (accept) begin
                x0_q    <= bus.cmd_x0;
                x1_q    <= bus.cmd_x1;
                y0_q    <= bus.cmd_y0;
                y1_q    <= bus.cmd_y1;
                color_q <= bus.cmd_color;
            end
            if (state_q == SETUP) begin
                x_q        <= x0_q;
                y_q        <= y0_q;
                row_base_q <= AVN_AW'(y0_q) * STRIDE;
            end
            // Counters only move on an accepted write, so a stall holds address and data.
            if (step) begin
                if (x_q < xe) begin
                    x_q <= x_q + XW'(1);
                end else if (y_q < ye) begin
                    x_q        <= x0_q;
                    y_q        <= y_q + YW'(1);
                    row_base_q <= row_base_q + STRIDE;
                end
            end
        end
    end

    assign bus.cmd_ready                  = ready;
    assign bus.busy                       = busy;
    assign bus.done                       = done;
    assign bus.framebuffer_avn_write      = write;
    assign bus.framebuffer_avn_address    = row_base_q + AVN_AW'(x_q);
    assign bus.framebuffer_avn_writedata  = color_q;
    assign bus.framebuffer_avn_byteenable = {(AVN_DW/8){write}};

endmodule
